// File: rtl/circle_path_ctrl.sv
// Six-digit circle display sequencer: 12-step loop, programmable rate.
// Define CIRCLE_BOUNCE_EN for ping-pong motion between pos 0 and 11.
module circle_path_ctrl #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       pause_i,
    input  logic       dir_i,
    input  logic [1:0] speed_i,
    output logic [2:0] col_o,
    output logic       row_o,
    output logic       step_o,
    output logic       lap_o,
    output logic       busy_o
);

    localparam int CW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [3:0]    r_pos;
    logic [3:0]    w_pos_nx;
    logic [3:0]    w_pos_step;
    logic [3:0]    w_mirror;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic [31:0]   w_limit;
    logic          w_tick;
    logic          w_fwd;
    logic          w_lap_step;
    logic          w_step_nx;
    logic          w_lap_nx;
    logic [2:0]    w_col_nx;
    logic          w_row_nx;

    logic [2:0]    r_col;
    logic          r_row;
    logic          r_step;
    logic          r_lap;
    logic          r_busy;

    // >= so a speed increase past the current count ticks at once
    assign w_limit = (32'(TICK_DIV) >> speed_i) - 32'd1;
    assign w_tick  = {{(32-CW){1'b0}}, r_cnt} >= w_limit;

`ifdef CIRCLE_BOUNCE_EN
    logic r_dir;
    logic w_dir_nx;

    always_comb begin
        w_fwd = ~r_dir;
        if (r_pos == 4'd0) begin
            w_fwd = 1'b1;
        end else if (r_pos == 4'd11) begin
            w_fwd = 1'b0;
        end
    end
`else
    assign w_fwd = ~dir_i;
`endif

    always_comb begin
        w_pos_step = r_pos;
        w_lap_step = 1'b0;
        if (w_fwd) begin
            if (r_pos >= 4'd11) begin
                w_pos_step = 4'd0;
                w_lap_step = 1'b1;
            end else begin
                w_pos_step = r_pos + 4'd1;
            end
        end else begin
            if (r_pos == 4'd0) begin
                w_pos_step = 4'd11;
                w_lap_step = 1'b1;
            end else begin
                w_pos_step = r_pos - 4'd1;
            end
        end
`ifdef CIRCLE_BOUNCE_EN
        w_lap_step = w_fwd ? (w_pos_step == 4'd11)
                           : (w_pos_step == 4'd0);
`endif
    end

    always_comb begin
        w_state_nx = r_state;
        w_pos_nx   = r_pos;
        w_cnt_nx   = r_cnt;
        w_step_nx  = 1'b0;
        w_lap_nx   = 1'b0;
`ifdef CIRCLE_BOUNCE_EN
        w_dir_nx   = r_dir;
`endif
        unique case (r_state)
            IDLE: begin
                w_pos_nx = 4'd0;
                w_cnt_nx = '0;
                if (start_i && !stop_i) begin
                    w_state_nx = RUN;
`ifdef CIRCLE_BOUNCE_EN
                    w_dir_nx   = dir_i;
`endif
                end
            end
            RUN: begin
                if (stop_i) begin
                    w_state_nx = IDLE;
                    w_pos_nx   = 4'd0;
                    w_cnt_nx   = '0;
                end else if (pause_i) begin
                    w_state_nx = PAUSE;
                end else if (w_tick) begin
                    w_cnt_nx  = '0;
                    w_pos_nx  = w_pos_step;
                    w_step_nx = 1'b1;
                    w_lap_nx  = w_lap_step;
`ifdef CIRCLE_BOUNCE_EN
                    w_dir_nx  = ~w_fwd;
`endif
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            PAUSE: begin
                if (stop_i) begin
                    w_state_nx = IDLE;
                    w_pos_nx   = 4'd0;
                    w_cnt_nx   = '0;
                end else if (!pause_i) begin
                    w_state_nx = RUN;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_pos_nx   = 4'd0;
                w_cnt_nx   = '0;
            end
        endcase
    end

    assign w_mirror = 4'd11 - w_pos_nx;

    always_comb begin
        w_col_nx = 3'd7;
        w_row_nx = 1'b0;
        if (w_state_nx != IDLE) begin
            if (w_pos_nx < 4'd6) begin
                w_col_nx = w_pos_nx[2:0];
                w_row_nx = 1'b1;
            end else begin
                w_col_nx = w_mirror[2:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_pos   <= 4'd0;
            r_cnt   <= '0;
            r_col   <= 3'd7;
            r_row   <= 1'b0;
            r_step  <= 1'b0;
            r_lap   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_pos   <= w_pos_nx;
            r_cnt   <= w_cnt_nx;
            r_col   <= w_col_nx;
            r_row   <= w_row_nx;
            r_step  <= w_step_nx;
            r_lap   <= w_lap_nx;
            r_busy  <= (w_state_nx != IDLE);
        end
    end

`ifdef CIRCLE_BOUNCE_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dir <= 1'b0;
        end else begin
            r_dir <= w_dir_nx;
        end
    end
`endif

    assign col_o  = r_col;
    assign row_o  = r_row;
    assign step_o = r_step;
    assign lap_o  = r_lap;
    assign busy_o = r_busy;

endmodule

// File: tb/tb_circle_path_ctrl.sv
// Self-checking bench for circle_path_ctrl against a position-table model.
module tb_circle_path_ctrl;

    localparam int TD = 8;

    logic       clk = 1'b0;
    logic       rst, start, stop, pause, dir;
    logic [1:0] speed;
    logic [2:0] col;
    logic       row, step, lap, busy;

    int checks = 0;
    int errors = 0;

    circle_path_ctrl #(.TICK_DIV(TD)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
        .pause_i(pause), .dir_i(dir), .speed_i(speed),
        .col_o(col), .row_o(row), .step_o(step), .lap_o(lap),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_RUN, M_PAUSE} mode_t;
    mode_t m_mode = M_IDLE;
    int    m_pos  = 0;
    int    m_acc  = 0;
    bit    m_dir  = 1'b0;
    int    COLS[12] = '{0, 1, 2, 3, 4, 5, 5, 4, 3, 2, 1, 0};
    int    ROWS[12] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    logic [2:0] e_col = 3'd7;
    logic       e_row = 1'b0, e_step = 1'b0, e_lap = 1'b0, e_busy = 1'b0;

    // reference: counts served RUN cycles and walks a position table
    initial forever begin
        @(posedge clk);
        e_step = 1'b0;
        e_lap  = 1'b0;
        if (rst) begin
            m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: if (start && !stop) begin
                    m_mode = M_RUN; m_pos = 0; m_acc = 0; m_dir = dir;
                end
                M_RUN: begin
                    if (stop) m_mode = M_IDLE;
                    else if (pause) m_mode = M_PAUSE;
                    else if (m_acc + 1 >= (TD >> speed)) begin
                        m_acc = 0;
                        e_step = 1'b1;
`ifdef CIRCLE_BOUNCE_EN
                        if (m_pos == 0) m_dir = 1'b0;
                        else if (m_pos == 11) m_dir = 1'b1;
                        m_pos = m_dir ? m_pos - 1 : m_pos + 1;
                        e_lap = (m_pos == 0) || (m_pos == 11);
`else
                        m_pos = dir ? (m_pos + 11) % 12 : (m_pos + 1) % 12;
                        e_lap = dir ? (m_pos == 11) : (m_pos == 0);
`endif
                    end else begin
                        m_acc++;
                    end
                end
                default: begin
                    if (stop) m_mode = M_IDLE;
                    else if (!pause) m_mode = M_RUN;
                end
            endcase
        end
        if (m_mode == M_IDLE) begin
            m_pos = 0; m_acc = 0;
            e_col = 3'd7; e_row = 1'b0; e_busy = 1'b0;
        end else begin
            e_col = 3'(COLS[m_pos]);
            e_row = ROWS[m_pos][0];
            e_busy = 1'b1;
        end
    end

    task automatic test_reset();
        rst = 1; start = 0; stop = 0; pause = 0; dir = 0; speed = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({col, row, step, lap, busy} !== 7'b111_0000) begin
            errors++;
            $display("FAIL reset got=%b want=%b",
                     {col, row, step, lap, busy}, 7'b111_0000);
        end
        rst = 0; start = 1;
        @(negedge clk);
        start = 0;
        checks++;
        if ({col, row, step, lap, busy} !== 7'b000_1001) begin
            errors++;
            $display("FAIL start got=%b want=%b",
                     {col, row, step, lap, busy}, 7'b000_1001);
        end
    endtask

    task automatic test_forward_lap();
        int steps = 0, laps = 0;
        speed = 0; dir = 0;
        for (int i = 0; i < 96; i++) begin
            @(negedge clk);
            steps += int'(step);
            laps  += int'(lap);
            checks++;
            if ({col, row, step, lap, busy} !==
                {e_col, e_row, e_step, e_lap, e_busy}) begin
                errors++;
                $display("FAIL fwd c%0d got=%b want=%b", i,
                         {col, row, step, lap, busy},
                         {e_col, e_row, e_step, e_lap, e_busy});
            end
        end
        checks++;
        if (steps != 12 || laps != 1) begin
            errors++;
            $display("FAIL fwd_counts got=%0d/%0d want=12/1", steps, laps);
        end
`ifndef CIRCLE_BOUNCE_EN
        checks++;
        if ({col, row} !== 4'b000_1) begin
            errors++;
            $display("FAIL fwd_end got=%b want=0001", {col, row});
        end
`endif
    endtask

    task automatic test_speed_dir();
        speed = 3; dir = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({col, row, step, lap, busy} !==
                {e_col, e_row, e_step, e_lap, e_busy}) begin
                errors++;
                $display("FAIL spd c%0d got=%b want=%b", i,
                         {col, row, step, lap, busy},
                         {e_col, e_row, e_step, e_lap, e_busy});
            end
`ifndef CIRCLE_BOUNCE_EN
            if (i == 0) begin
                checks++;
                if ({col, row, step, lap} !== 6'b000_011) begin
                    errors++;
                    $display("FAIL rev_wrap got=%b want=000011",
                             {col, row, step, lap});
                end
            end
`endif
        end
        stop = 1;
        @(negedge clk);
        stop = 0; start = 1; speed = 0; dir = 0;
        @(negedge clk);
        start = 0;
        repeat (5) @(negedge clk);
        speed = 2;
        @(negedge clk);
        checks++;
        if (step !== 1'b1 || step !== e_step) begin
            errors++;
            $display("FAIL spd_change step=%b want=1", step);
        end
        speed = 0;
    endtask

    task automatic test_pause_stop();
        int n = 0;
        while (step !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (step !== 1'b1) begin
            errors++;
            $display("FAIL wait_step got=%b want=1 (timeout)", step);
        end
        repeat (3) @(negedge clk);
        pause = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({col, row, step, lap, busy} !==
                {e_col, e_row, 2'b00, 1'b1}) begin
                errors++;
                $display("FAIL pause c%0d got=%b want=%b", i,
                         {col, row, step, lap, busy},
                         {e_col, e_row, 3'b001});
            end
        end
        pause = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (step !== 1'b1 && n < 40);
        checks++;
        if (n != 1 + (TD - 3)) begin
            errors++;
            $display("FAIL resume got=%0d want=%0d", n, 1 + (TD - 3));
        end
        repeat (TD - 1) @(negedge clk);
        stop = 1;
        @(negedge clk);
        stop = 0;
        checks++;
        if ({col, step, busy} !== 5'b111_00 ||
            {col, step, busy} !== {e_col, e_step, e_busy}) begin
            errors++;
            $display("FAIL stop_tick got=%b want=11100", {col, step, busy});
        end
    endtask

    task automatic test_simultaneous();
        start = 1; stop = 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({col, busy} !== 4'b111_0) begin
            errors++;
            $display("FAIL start_stop got=%b want=1110", {col, busy});
        end
        stop = 0;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        pause = 1; stop = 1;
        @(negedge clk);
        pause = 0; stop = 0;
        checks++;
        if ({col, busy} !== 4'b111_0) begin
            errors++;
            $display("FAIL pause_stop got=%b want=1110", {col, busy});
        end
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        pause = 1;
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0; pause = 0;
        checks++;
        if ({col, row, step, lap, busy} !== 7'b111_0000) begin
            errors++;
            $display("FAIL rst_pause got=%b want=1110000",
                     {col, row, step, lap, busy});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            pause = ($urandom_range(0, 9) == 0);
            dir   = ($urandom_range(0, 5) == 0) ? ~dir : dir;
            if ($urandom_range(0, 49) == 0) speed = 2'($urandom_range(0, 3));
            @(negedge clk);
            checks++;
            if ({col, row, step, lap, busy} !==
                {e_col, e_row, e_step, e_lap, e_busy}) begin
                errors++;
                $display("FAIL rand c%0d got=%b want=%b", i,
                         {col, row, step, lap, busy},
                         {e_col, e_row, e_step, e_lap, e_busy});
            end
        end
        rst = 0; start = 0; stop = 0; pause = 0;
    endtask

    initial begin
        rst = 1; start = 0; stop = 0; pause = 0; dir = 0; speed = 0;
        test_reset();
        test_forward_lap();
        test_speed_dir();
        test_pause_stop();
        test_simultaneous();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
